// File: rtl/ts_pkg.sv
// Shared constants, FSM state types and saturating-counter helpers for the TS front end.
package ts_pkg;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;
    localparam int         TS_PID_W     = 13;

    typedef enum logic {
        PKT_HUNT = 1'b0,
        PKT_DATA = 1'b1
    } pkt_state_e;

    typedef enum logic [1:0] {
        BUF_WAIT   = 2'd0,
        BUF_FILL   = 2'd1,
        BUF_COMMIT = 2'd2
    } buf_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/ts_deser.sv
// Serial/parallel TS deserialiser for the selected channel: emits a registered byte strobe
// with a start flag marking the first byte of a packet.
module ts_deser
    import ts_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_ser_mode,
    output logic       o_done,
    output logic [7:0] o_byte,
    output logic       o_start
);
    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_prev_start;
    logic       r_start_pend;
    logic       w_restart;

    // Start is held for a whole serial byte, so only its rising edge realigns the bit counter.
    always_comb begin
        w_restart = i_start && !r_prev_start;
    end

    // Bit shifting and byte assembly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= 7'd0;
            r_bit_cnt    <= 3'd0;
            r_prev_start <= 1'b0;
            r_start_pend <= 1'b0;
            o_done       <= 1'b0;
            o_byte       <= 8'd0;
            o_start      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_valid) begin
                r_prev_start <= i_start;
                if (i_ser_mode) begin
                    if (w_restart) begin
                        r_shift      <= {6'd0, i_data[0]};
                        r_bit_cnt    <= 3'd1;
                        r_start_pend <= 1'b1;
                    end else if (r_bit_cnt == 3'd7) begin
                        o_done       <= 1'b1;
                        o_byte       <= {r_shift, i_data[0]};
                        o_start      <= r_start_pend;
                        r_bit_cnt    <= 3'd0;
                        r_start_pend <= 1'b0;
                    end else begin
                        r_shift   <= {r_shift[5:0], i_data[0]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end else begin
                    o_done    <= 1'b1;
                    o_byte    <= i_data;
                    o_start   <= i_start;
                    r_bit_cnt <= 3'd0;
                end
            end
        end
    end
endmodule

// File: rtl/ts_mux_packer.sv
// Multi-channel TS mux, sync check and EP IN buffer packer with fixed-length commits.
// Optional statistics counters are enabled with the TS_STATS_EN macro.
module ts_mux_packer
    import ts_pkg::*;
#(
    parameter int  NCH     = 4,
    parameter int  ADDR_W  = 11,
    parameter int  PKT_LEN = TS_PKT_LEN,
    localparam int CH_W    = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      i_ts_start,
    input  logic [NCH-1:0]      i_ts_valid,
    input  logic [NCH*8-1:0]    i_ts_data,
    input  logic                i_ser_mode,
    input  logic [CH_W-1:0]     i_insel,
    input  logic [ADDR_W-1:0]   i_commit_len,
    output logic [7:0]          o_ep_in_data,
    output logic [ADDR_W-1:0]   o_ep_in_addr,
    output logic                o_ep_in_wren,
    output logic                o_ep_in_commit,
    output logic [ADDR_W-1:0]   o_ep_in_commit_len,
    input  logic                i_ep_in_ready,
    input  logic                i_ep_in_commit_ack
`ifdef TS_STATS_EN
    ,
    output logic [31:0]         o_pkt_cnt,
    output logic [15:0]         o_sync_err_cnt,
    output logic [15:0]         o_ovf_cnt
`endif
);
    localparam int CNT_W = $clog2(PKT_LEN + 1);

    logic [CH_W-1:0]   r_ch;
    pkt_state_e        r_pkt_st;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic              r_drop;
    buf_state_e        r_buf_st;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_len;

    logic              w_bdone;
    logic [7:0]        w_byte;
    logic              w_bstart;
    logic              w_pkt_first;
    logic              w_pkt_cont;
    logic              w_pkt_byte;
    logic              w_last;
    logic              w_drop_now;
    logic              w_write;
    logic [ADDR_W-1:0] w_len_eff;

    ts_deser u_deser (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_ts_valid[r_ch]),
        .i_start    (i_ts_start[r_ch]),
        .i_data     (i_ts_data[{r_ch, 3'b000} +: 8]),
        .i_ser_mode (i_ser_mode),
        .o_done     (w_bdone),
        .o_byte     (w_byte),
        .o_start    (w_bstart)
    );

    // Classify each byte; a packet that hit a full buffer stays dropped until the next sync.
    always_comb begin
        w_pkt_first = w_bdone && w_bstart && (w_byte == TS_SYNC_BYTE);
        w_pkt_cont  = w_bdone && !w_bstart && (r_pkt_st == PKT_DATA);
        w_pkt_byte  = w_pkt_first || w_pkt_cont;
        w_last      = w_pkt_cont && (r_byte_cnt == CNT_W'(PKT_LEN - 1));
        if (w_pkt_first) begin
            w_drop_now = (r_buf_st != BUF_FILL);
        end else begin
            w_drop_now = r_drop || (r_buf_st != BUF_FILL);
        end
        w_write = w_pkt_byte && !w_drop_now;
        if (i_commit_len == '0) begin
            w_len_eff = '1;
        end else begin
            w_len_eff = i_commit_len;
        end
    end

    // Packet framing, channel selection and per-packet drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_st   <= PKT_HUNT;
            r_byte_cnt <= '0;
            r_ch       <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (w_bdone && w_bstart) begin
                if (w_pkt_first) begin
                    r_pkt_st   <= PKT_DATA;
                    r_byte_cnt <= CNT_W'(1);
                end else begin
                    r_pkt_st   <= PKT_HUNT;
                    r_byte_cnt <= '0;
                end
            end else if (w_pkt_cont) begin
                if (w_last) begin
                    r_pkt_st   <= PKT_HUNT;
                    r_byte_cnt <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                end
            end
            if (r_pkt_st == PKT_HUNT && !w_pkt_first) begin
                r_ch <= i_insel;
            end
            if (w_pkt_byte) begin
                r_drop <= w_drop_now;
            end
        end
    end

    // Buffer fill / commit handshake with registered EP outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_st           <= BUF_WAIT;
            r_ptr              <= '0;
            r_len              <= '0;
            o_ep_in_wren       <= 1'b0;
            o_ep_in_data       <= 8'd0;
            o_ep_in_addr       <= '0;
            o_ep_in_commit     <= 1'b0;
            o_ep_in_commit_len <= '0;
        end else begin
            o_ep_in_wren <= 1'b0;
            case (r_buf_st)
                BUF_WAIT: begin
                    if (i_ep_in_ready) begin
                        r_buf_st <= BUF_FILL;
                        r_len    <= w_len_eff;
                    end
                end
                BUF_FILL: begin
                    if (w_write) begin
                        o_ep_in_wren <= 1'b1;
                        o_ep_in_data <= w_byte;
                        o_ep_in_addr <= r_ptr;
                        if ((r_ptr + ADDR_W'(1)) == r_len) begin
                            r_buf_st           <= BUF_COMMIT;
                            o_ep_in_commit     <= 1'b1;
                            o_ep_in_commit_len <= r_len;
                        end else begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end
                end
                BUF_COMMIT: begin
                    if (i_ep_in_commit_ack) begin
                        o_ep_in_commit <= 1'b0;
                        r_ptr          <= '0;
                        r_buf_st       <= BUF_WAIT;
                    end
                end
                default: begin
                    r_buf_st       <= BUF_WAIT;
                    o_ep_in_commit <= 1'b0;
                end
            endcase
        end
    end

`ifdef TS_STATS_EN
    // Saturating statistics; overflow counts once per dropped packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_pkt_cnt      <= 32'd0;
            o_sync_err_cnt <= 16'd0;
            o_ovf_cnt      <= 16'd0;
        end else begin
            if (w_bdone && w_bstart && !w_pkt_first) begin
                o_sync_err_cnt <= sat_inc16(o_sync_err_cnt);
            end
            if (w_pkt_byte && w_drop_now && (w_pkt_first || !r_drop)) begin
                o_ovf_cnt <= sat_inc16(o_ovf_cnt);
            end
            if (w_write && w_last) begin
                o_pkt_cnt <= sat_inc32(o_pkt_cnt);
            end
        end
    end
`endif
endmodule

// File: tb/tb_ts_mux_packer.sv
// Directed self-checking bench for ts_mux_packer (statistics checks active with TS_STATS_EN).
`timescale 1ns/1ps
module tb_ts_mux_packer;
    localparam int NCH    = 4;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    ts_start = '0;
    logic [NCH-1:0]    ts_valid = '0;
    logic [NCH*8-1:0]  ts_data = '0;
    logic              ser_mode = 1'b0;
    logic [1:0]        insel = 2'd0;
    logic [ADDR_W-1:0] commit_len = 11'd188;
    logic              ready = 1'b0;
    logic              ack = 1'b0;
    logic [7:0]        ep_data;
    logic [ADDR_W-1:0] ep_addr;
    logic              ep_wren;
    logic              ep_commit;
    logic [ADDR_W-1:0] ep_commit_len;
`ifdef TS_STATS_EN
    logic [31:0]       pkt_cnt;
    logic [15:0]       sync_err_cnt;
    logic [15:0]       ovf_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic              auto_ack = 1'b1;
    logic              prev_commit = 1'b0;
    logic [7:0]        mon_data[$];
    logic [ADDR_W-1:0] mon_addr[$];
    logic [ADDR_W-1:0] mon_clen[$];

    ts_mux_packer #(.NCH(NCH), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_ts_start         (ts_start),
        .i_ts_valid         (ts_valid),
        .i_ts_data          (ts_data),
        .i_ser_mode         (ser_mode),
        .i_insel            (insel),
        .i_commit_len       (commit_len),
        .o_ep_in_data       (ep_data),
        .o_ep_in_addr       (ep_addr),
        .o_ep_in_wren       (ep_wren),
        .o_ep_in_commit     (ep_commit),
        .o_ep_in_commit_len (ep_commit_len),
        .i_ep_in_ready      (ready),
        .i_ep_in_commit_ack (ack)
`ifdef TS_STATS_EN
        ,
        .o_pkt_cnt          (pkt_cnt),
        .o_sync_err_cnt     (sync_err_cnt),
        .o_ovf_cnt          (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Capture EP writes and commit requests; acknowledge commits when auto_ack is set.
    always @(negedge clk) begin
        if (ep_wren) begin
            mon_data.push_back(ep_data);
            mon_addr.push_back(ep_addr);
        end
        if (ep_commit && !prev_commit) mon_clen.push_back(ep_commit_len);
        prev_commit = ep_commit;
        ack = auto_ack && ep_commit;
    end

    task automatic clear_mon;
        mon_data.delete();
        mon_addr.delete();
        mon_clen.delete();
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] len);
        @(negedge clk);
        reset = 1'b1;
        ts_valid = '0; ts_start = '0; ts_data = '0;
        ready = 1'b0; auto_ack = 1'b1; commit_len = len;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        @(negedge clk);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b, input logic st);
        if (ser_mode) begin
            for (int i = 7; i >= 0; i--) begin
                @(negedge clk);
                ts_valid[ch] = 1'b1;
                ts_start[ch] = st;
                ts_data[ch*8 +: 8] = {7'd0, b[i]};
                @(negedge clk);
                ts_valid[ch] = 1'b0;
            end
            ts_start[ch] = 1'b0;
        end else begin
            @(negedge clk);
            ts_valid[ch] = 1'b1;
            ts_start[ch] = st;
            ts_data[ch*8 +: 8] = b;
            @(negedge clk);
            ts_valid[ch] = 1'b0;
            ts_start[ch] = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    // inc=1: byte k of the packet carries k[7:0]; otherwise every body byte is fill.
    task automatic send_pkt(input int ch, input logic [7:0] first, input logic [7:0] fill, input bit inc);
        for (int k = 0; k < 188; k++) begin
            if (k == 0) send_byte(ch, first, 1'b1);
            else if (inc) send_byte(ch, 8'(k), 1'b0);
            else send_byte(ch, fill, 1'b0);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        checks++; if (ep_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b want=0", ep_wren); end
        checks++; if (ep_commit !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b want=0", ep_commit); end
        checks++; if (ep_addr !== 11'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", ep_addr); end
        checks++; if (ep_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%h want=00", ep_data); end
        checks++; if (ep_commit_len !== 11'd0) begin errors++; $display("FAIL reset_clen got=%0d want=0", ep_commit_len); end
    endtask

    task automatic test_serial;
        int bad_a, bad_d;
        do_reset(11'd188);
        ready = 1'b1; ser_mode = 1'b1; insel = 2'd2;
        send_pkt(2, 8'h47, 8'hAA, 1'b0);
        bad_a = 0; bad_d = 0;
        foreach (mon_addr[i]) begin
            if (mon_addr[i] !== 11'(i)) bad_a++;
            if (mon_data[i] !== ((i == 0) ? 8'h47 : 8'hAA)) bad_d++;
        end
        checks++; if (mon_data.size() != 188) begin errors++; $display("FAIL ser_writes got=%0d want=188", mon_data.size()); end
        checks++; if (bad_a != 0) begin errors++; $display("FAIL ser_addr_seq bad=%0d want=0", bad_a); end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL ser_data bad=%0d want=0", bad_d); end
        checks++; if (mon_clen.size() != 1) begin errors++; $display("FAIL ser_commits got=%0d want=1", mon_clen.size()); end
        else begin
            checks++; if (mon_clen[0] !== 11'd188) begin errors++; $display("FAIL ser_clen got=%0d want=188", mon_clen[0]); end
        end
        ser_mode = 1'b0;
    endtask

    task automatic test_sync_err;
        do_reset(11'd188);
        ready = 1'b1; insel = 2'd0;
        send_pkt(0, 8'h46, 8'hAA, 1'b0);
        checks++; if (mon_data.size() != 0) begin errors++; $display("FAIL sync_bad_writes got=%0d want=0", mon_data.size()); end
`ifdef TS_STATS_EN
        checks++; if (sync_err_cnt !== 16'd1) begin errors++; $display("FAIL sync_err_cnt got=%0d want=1", sync_err_cnt); end
`endif
        send_pkt(0, 8'h47, 8'h5A, 1'b0);
        checks++; if (mon_data.size() != 188) begin errors++; $display("FAIL sync_good_writes got=%0d want=188", mon_data.size()); end
        else begin
            checks++; if (mon_data[187] !== 8'h5A) begin errors++; $display("FAIL sync_good_last got=%h want=5a", mon_data[187]); end
        end
        checks++; if (mon_clen.size() != 1) begin errors++; $display("FAIL sync_commits got=%0d want=1", mon_clen.size()); end
    endtask

    task automatic test_overflow;
        do_reset(11'd188);
        ready = 1'b0; insel = 2'd0;
        for (int k = 0; k < 188; k++) begin
            if (k == 10) ready = 1'b1;
            send_byte(0, (k == 0) ? 8'h47 : 8'hC3, k == 0);
        end
        repeat (10) @(negedge clk);
        checks++; if (mon_data.size() != 0) begin errors++; $display("FAIL ovf_writes got=%0d want=0", mon_data.size()); end
`ifdef TS_STATS_EN
        checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt got=%0d want=1", ovf_cnt); end
`endif
        send_pkt(0, 8'h47, 8'h3C, 1'b0);
        checks++; if (mon_data.size() != 188) begin errors++; $display("FAIL ovf_next_writes got=%0d want=188", mon_data.size()); end
        else begin
            checks++; if (mon_addr[0] !== 11'd0) begin errors++; $display("FAIL ovf_next_addr0 got=%0d want=0", mon_addr[0]); end
        end
    endtask

    task automatic test_commit_split;
        int bad_a;
        do_reset(11'd1020);
        ready = 1'b1; insel = 2'd0;
        for (int p = 0; p < 6; p++) send_pkt(0, 8'h47, 8'h00, 1'b1);
        checks++; if (mon_data.size() != 1128) begin errors++; $display("FAIL split_writes got=%0d want=1128", mon_data.size()); end
        else begin
            bad_a = 0;
            foreach (mon_addr[i]) if (mon_addr[i] !== ((i < 1020) ? 11'(i) : 11'(i - 1020))) bad_a++;
            checks++; if (bad_a != 0) begin errors++; $display("FAIL split_addr_seq bad=%0d want=0", bad_a); end
            checks++; if (mon_addr[1127] !== 11'd107) begin errors++; $display("FAIL split_last_addr got=%0d want=107", mon_addr[1127]); end
            checks++; if (mon_data[1020] !== 8'h50) begin errors++; $display("FAIL split_resume_data got=%h want=50", mon_data[1020]); end
        end
        checks++; if (mon_clen.size() != 1) begin errors++; $display("FAIL split_commits got=%0d want=1", mon_clen.size()); end
        else begin
            checks++; if (mon_clen[0] !== 11'd1020) begin errors++; $display("FAIL split_clen got=%0d want=1020", mon_clen[0]); end
        end
`ifdef TS_STATS_EN
        checks++; if (pkt_cnt !== 32'd6) begin errors++; $display("FAIL split_pkt_cnt got=%0d want=6", pkt_cnt); end
`endif
    endtask

    task automatic test_insel;
        int n22;
        do_reset(11'd188);
        ready = 1'b1; insel = 2'd0;
        for (int k = 0; k < 94; k++) send_byte(0, (k == 0) ? 8'h47 : 8'h11, k == 0);
        insel = 2'd1;
        for (int k = 0; k < 20; k++) send_byte(1, (k == 0) ? 8'h47 : 8'h22, k == 0);
        for (int k = 94; k < 188; k++) send_byte(0, 8'h11, 1'b0);
        for (int k = 0; k < 20; k++) send_byte(1, 8'h22, 1'b0);
        send_pkt(1, 8'h47, 8'h33, 1'b0);
        n22 = 0;
        foreach (mon_data[i]) if (mon_data[i] === 8'h22) n22++;
        checks++; if (mon_data.size() != 376) begin errors++; $display("FAIL insel_writes got=%0d want=376", mon_data.size()); end
        else begin
            checks++; if (mon_data[187] !== 8'h11) begin errors++; $display("FAIL insel_ch0_last got=%h want=11", mon_data[187]); end
            checks++; if (mon_data[189] !== 8'h33) begin errors++; $display("FAIL insel_ch1_body got=%h want=33", mon_data[189]); end
        end
        checks++; if (n22 != 0) begin errors++; $display("FAIL insel_stray_bytes got=%0d want=0", n22); end
        checks++; if (mon_clen.size() != 2) begin errors++; $display("FAIL insel_commits got=%0d want=2", mon_clen.size()); end
    endtask

    task automatic test_reset_commit;
        do_reset(11'd10);
        ready = 1'b1; auto_ack = 1'b0; insel = 2'd0;
        for (int k = 0; k < 9; k++) send_byte(0, (k == 0) ? 8'h47 : 8'(k), k == 0);
        @(negedge clk);
        ts_valid[0] = 1'b1; ts_data[7:0] = 8'h09;
        @(negedge clk);
        ts_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ep_commit !== 1'b1) begin errors++; $display("FAIL rc_commit_pre got=%b want=1", ep_commit); end
        checks++; if (ep_wren !== 1'b1 || ep_addr !== 11'd9) begin errors++; $display("FAIL rc_wren_pre got=%b/%0d want=1/9", ep_wren, ep_addr); end
        reset = 1'b1;
        #1;
        checks++; if (ep_commit !== 1'b0) begin errors++; $display("FAIL rc_commit_drop got=%b want=0", ep_commit); end
        checks++; if (ep_wren !== 1'b0) begin errors++; $display("FAIL rc_wren_drop got=%b want=0", ep_wren); end
        @(negedge clk);
        reset = 1'b0; auto_ack = 1'b1;
        clear_mon();
        send_pkt(0, 8'h47, 8'h77, 1'b0);
        checks++; if (mon_data.size() != 188) begin errors++; $display("FAIL rc_writes got=%0d want=188", mon_data.size()); end
        else begin
            checks++; if (mon_addr[0] !== 11'd0 || mon_addr[10] !== 11'd0) begin errors++; $display("FAIL rc_restart_addr got=%0d/%0d want=0/0", mon_addr[0], mon_addr[10]); end
            checks++; if (mon_addr[187] !== 11'd7) begin errors++; $display("FAIL rc_last_addr got=%0d want=7", mon_addr[187]); end
        end
        checks++; if (mon_clen.size() != 18) begin errors++; $display("FAIL rc_commits got=%0d want=18", mon_clen.size()); end
    endtask

    initial begin
        test_reset();
        test_serial();
        test_sync_err();
        test_overflow();
        test_commit_split();
        test_insel();
        test_reset_commit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
